// File: rtl/data_ram.sv
// Byte-addressed little-endian data memory with byte/half/word access, sign/zero-extending
// loads, error responses and a fixed-latency in-order response pipeline.
module data_ram #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] idx_t;

  logic        ready_q, ready_d;
  logic        accept;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic [3:0]  byte_en;
  idx_t        base;
  idx_t        byte_idx [4];
  logic [7:0]  rd_byte  [4];
  logic [31:0] load_data;
  logic        sext;

  logic [7:0]  mem_q [Depth];

  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [READ_LATENCY-1:0] err_q, err_d;
  logic [31:0]             rdata_q [READ_LATENCY];
  logic [31:0]             rdata_d [READ_LATENCY];

  // Ready rises on the first edge after reset release and then stays high.
  always_comb begin
    ready_d = 1'b1;
  end

  assign req_ready = ready_q;
  assign accept    = req_valid && ready_q;

  always_comb begin
    base         = req_addr[ADDR_WIDTH-1:0];
    misaligned   = 1'b0;
    byte_en      = 4'b0000;
    case (req_size)
      2'd0: byte_en = 4'b0001;
      2'd1: begin
        byte_en    = 4'b0011;
        misaligned = req_addr[0];
      end
      2'd2: begin
        byte_en    = 4'b1111;
        misaligned = |req_addr[1:0];
      end
      default: byte_en = 4'b0000;
    endcase
    out_of_range = |(req_addr >> ADDR_WIDTH);
    req_err      = (req_size == 2'd3) || misaligned || out_of_range;
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      byte_idx[k] = base + idx_t'(k);
      rd_byte[k]  = mem_q[byte_idx[k]];
    end
  end

  always_comb begin
    load_data = '0;
    case (req_size)
      2'd0: begin
        sext      = !req_unsigned && rd_byte[0][7];
        load_data = {{24{sext}}, rd_byte[0]};
      end
      2'd1: begin
        sext      = !req_unsigned && rd_byte[1][7];
        load_data = {{16{sext}}, rd_byte[1], rd_byte[0]};
      end
      default: begin
        sext      = 1'b0;
        load_data = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
      end
    endcase
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (accept && req_write && !req_err && !reset) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) begin
          mem_q[byte_idx[k]] <= req_wdata[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    vld_d      = '0;
    err_d      = '0;
    vld_d[0]   = accept;
    err_d[0]   = accept && req_err;
    rdata_d[0] = (accept && !req_write && !req_err) ? load_data : 32'h0;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i]   = vld_q[i-1];
      err_d[i]   = err_q[i-1];
      rdata_d[i] = rdata_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
      vld_q   <= '0;
      err_q   <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        rdata_q[i] <= '0;
      end
    end else begin
      ready_q <= ready_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      for (int i = 0; i < READ_LATENCY; i++) begin
        rdata_q[i] <= rdata_d[i];
      end
    end
  end

  assign rsp_valid = vld_q[READ_LATENCY-1];
  assign rsp_error = err_q[READ_LATENCY-1];
  assign rsp_rdata = rdata_q[READ_LATENCY-1];

endmodule

// File: tb/tb_data_ram.sv
// Scoreboard bench for data_ram: one stimulus stream drives a latency-1 and a latency-3
// instance; a byte-array reference model predicts every response.
module tb_data_ram;

  localparam int unsigned AW = 10;
  localparam int MemBytes = 1 << AW;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;

  logic        ready1, rsp_valid1, rsp_error1;
  logic [31:0] rsp_rdata1;
  logic        ready3, rsp_valid3, rsp_error3;
  logic [31:0] rsp_rdata3;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  logic [7:0] ref_mem [MemBytes];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  data_ram #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid1),
    .rsp_rdata(rsp_rdata1), .rsp_error(rsp_error1)
  );

  data_ram #(.ADDR_WIDTH(AW), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready3),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid3),
    .rsp_rdata(rsp_rdata3), .rsp_error(rsp_error3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cmp_rsp(input string tag, input exp_t e, input logic [31:0] rd, input logic er);
    chk({tag, " rdata"}, 64'(rd), 64'(e.rdata));
    chk({tag, " error"}, 64'(er), 64'(e.err));
    chk({tag, " latency"}, 64'(cyc), 64'(e.due));
  endtask

  always @(negedge clk) begin
    if (rsp_valid1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL lat1 unexpected response: got rdata %0h expected none", rsp_rdata1);
      end else begin
        cmp_rsp("lat1", q1.pop_front(), rsp_rdata1, rsp_error1);
      end
    end else begin
      chk("lat1 idle outputs", {31'b0, rsp_error1, rsp_rdata1}, 64'h0);
    end
  end

  always @(negedge clk) begin
    if (rsp_valid3) begin
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL lat3 unexpected response: got rdata %0h expected none", rsp_rdata3);
      end else begin
        cmp_rsp("lat3", q3.pop_front(), rsp_rdata3, rsp_error3);
      end
    end else begin
      chk("lat3 idle outputs", {31'b0, rsp_error3, rsp_rdata3}, 64'h0);
    end
  end

  // Reference model: plain byte array, little-endian assembly, arithmetic sign extension.
  task automatic model(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] wd, output logic e, output logic [31:0] rd);
    int n;
    longint v;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e  = (sz == 2'd3) || ((a % n) != 0) || (a >= MemBytes);
    rd = '0;
    if (!e) begin
      if (w) begin
        for (int k = 0; k < n; k++) ref_mem[a + k] = 8'(wd >> (8 * k));
      end else begin
        v = 0;
        for (int k = 0; k < n; k++) v += longint'(ref_mem[a + k]) << (8 * k);
        if (n < 4 && !u && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        rd = 32'(v);
      end
    end
  endtask

  // Called at posedge+1; presents one request for one edge.
  task automatic issue(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] wd);
    logic acc;
    int c;
    logic e;
    logic [31:0] rd;
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = wd;
    acc = ready1;
    c   = cyc;
    @(posedge clk);
    #1;
    if (acc) begin
      model(w, sz, u, a, wd, e, rd);
      q1.push_back('{err: e, rdata: rd, due: c + 1});
      q3.push_back('{err: e, rdata: rd, due: c + 3});
    end
    req_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] sz;
    logic [31:0] a;

    repeat (3) @(posedge clk);
    #1;
    chk("ready low in reset", {ready3, ready1}, 64'h0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    chk("ready low before first edge", {ready3, ready1}, 64'h0);
    @(posedge clk);
    #1;
    chk("ready high after first edge", {ready3, ready1}, 64'h3);

    // Directed accesses
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D);
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    issue(1'b1, 2'd0, 1'b0, 32'h11, 32'hA5A5A555);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h12, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'h21, 32'h1234);
    issue(1'b1, 2'd3, 1'b0, 32'h20, 32'hFFFFFFFF);
    issue(1'b0, 2'd2, 1'b0, MemBytes, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    idle();

    // Fill low 64 bytes, then back-to-back loads
    for (int i = 0; i < 16; i++) issue(1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom);
    for (int i = 0; i < 4; i++) issue(1'b0, 2'd2, 1'b0, 32'(4 * i), 32'h0);
    repeat (2) idle();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 15) == 0) ? 32'(MemBytes + $urandom_range(0, 4095))
                                        : 32'($urandom_range(0, 63));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end
    repeat (5) idle();

    // Reset with two loads in flight and a store presented on the reset edge
    issue(1'b0, 2'd2, 1'b0, 32'h00, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h04, 32'h0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'd2;
    req_addr  = 32'h08;
    req_wdata = 32'h12345678;
    @(negedge clk);
    #1;
    reset = 1'b1;
    q1.delete();
    q3.delete();
    #1;
    chk("ready drops on async reset", {ready3, ready1}, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("ready high after recovery", {ready3, ready1}, 64'h3);
    issue(1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h0A, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 32'h0B, 32'h0);
    repeat (6) idle();

    chk("lat1 queue drained", 64'(q1.size()), 64'h0);
    chk("lat3 queue drained", 64'(q3.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_ram.md
# data_ram

Byte-addressed, little-endian data memory for the RISC-V core's load/store path, replacing the fixed 1 kB word-only RAM. Supports byte, halfword and word accesses with sign/zero extension on loads, a valid/ready request port, a fixed-latency in-order response pipeline, and error responses for misaligned, out-of-range or illegal-size accesses. Sits between the core's memory stage and the bus, one request per cycle.

## Interface
- ADDR_WIDTH, 10, byte-address bits decoded; capacity 2^ADDR_WIDTH bytes (legal 4..20)
- READ_LATENCY, 1, cycles from request acceptance to response (legal 1..4)
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, least-significant bytes used per size
- rsp_valid  output  1  response valid, one cycle pulse per accepted request
- rsp_rdata  output  32  load result; 0 for stores and errors
- rsp_error  output  1  request rejected; no memory side effect

## Operation
- Accept = req_valid && req_ready on a rising edge. Every accepted request yields exactly one response, in order.
- Error checks at accept: size 3; halfword with addr[0]=1; word with addr[1:0]≠0; any addr bit at or above ADDR_WIDTH set. Error -> no write, rsp_error=1, rsp_rdata=0.
- Store: bytes addr..addr+N-1 (N=1/2/4) written at the accepting edge with req_wdata[8N-1:0], byte k of data to addr+k. Other bytes untouched.
- Load: bytes read at the accepting edge (post-write of any earlier-accepted store), assembled little-endian, extended per req_unsigned; word loads ignore req_unsigned.
- Memory array is not reset; contents undefined until written.
- Response pipeline: READ_LATENCY stages each holding valid, error, rdata; stage 0 loaded at accept, shifted every cycle. No response backpressure: consumer must take rsp_valid when asserted.
- req_ready: 0 during reset and on the first edge after reset deasserts; 1 thereafter permanently.

## Timing
- Reset (async): all pipeline valid bits, rsp_valid, rsp_error, rsp_rdata, req_ready -> 0 immediately. In-flight requests dropped, no response ever issued. A store whose accepting edge coincides with reset asserted is not performed.
- First edge with reset low sets req_ready=1; first acceptance possible on the following edge.
- Request accepted at edge T -> rsp_valid high for the cycle after edge T+READ_LATENCY-1 (i.e. visible after edge T+READ_LATENCY-1 when READ_LATENCY=1: the cycle following T).
- Throughput: one request per cycle; back-to-back responses on consecutive cycles.
- Store at edge T, load of same bytes at edge T+1 returns new data. Load and store cannot be accepted on the same edge (single port).
- rsp_rdata and rsp_error are 0 whenever rsp_valid is 0.

## Test plan
- Reset then word store 0xDEADBEEF at 0x10, load word 0x10 -> rsp_rdata 0xDEADBEEF, rsp_error 0, rsp_valid exactly READ_LATENCY cycles after accept.
- After above: load byte 0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; halfword 0x10 signed -> 0xFFFFBEEF; unsigned halfword 0x12 -> 0x0000DEAD.
- Store byte 0x55 to 0x11 then load word 0x10 back-to-back -> 0xDEAD55EF; untouched bytes preserved.
- Word load at 0x12, halfword store at 0x21, size 3, word load at 2^ADDR_WIDTH -> each rsp_error 1, rsp_rdata 0; subsequent load of 0x20 shows no change.
- READ_LATENCY=3: 4 consecutive loads of 0x00,0x04,0x08,0x0C with known data -> 4 consecutive rsp_valid cycles, data in order.
- Assert reset with 2 loads in flight and a store accepting same edge -> rsp_valid never rises for them; after recovery load shows store not performed; req_ready low for one edge after release.
